// File: rtl/result_matrix_buffer_pkg.sv
// Shared types for the result matrix write-back stage.
// State encoding and the element data width.
package result_matrix_buffer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCEPT = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/result_regfile.sv
// m*m x 32 result storage: two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, writes visible after the clock edge.
// Backpressure: none; the owner decides when to write.
module result_regfile
  import result_matrix_buffer_pkg::*;
#(
  parameter int m     = 4,
  parameter int m_len = $clog2(m)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [2*m_len-1:0]   waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [2*m_len-1:0]   raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic [2*m_len-1:0]   raddr_b,
  output logic [DATA_W-1:0]    rdata_b
);

  logic [DATA_W-1:0] mem [m*m];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/result_matrix_buffer.sv
// Holds result matrix Z for row_col_multiplier, acks element updates, then streams Z row-major.
// Latency: z_ack one cycle after an accepted strobe; stream starts the cycle after mul_done.
// Backpressure: stream outputs hold while out_ready=0; held strobes are acked only once.
module result_matrix_buffer
  import result_matrix_buffer_pkg::*;
#(
  parameter int m     = 4,
  parameter int m_len = $clog2(m)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  z_out,
  input  logic [m_len-1:0]   z_i,
  input  logic [m_len-1:0]   z_j,
  input  logic               z_stb,
  output logic               z_ack,
  output logic [DATA_W-1:0]  current_element,
  input  logic               mul_done,
  output logic [DATA_W-1:0]  out_data,
  output logic [m_len-1:0]   out_i,
  output logic [m_len-1:0]   out_j,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = 2*m_len;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(m*m-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  clr_cnt, rd_cnt;
  logic              seen;
  logic              wr_acc, xfer, we;
  logic [CNT_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  // seen blocks re-writes from a strobe held high past its ack
  assign wr_acc = (state == ACCEPT) && z_stb && !z_ack && !seen;
  assign xfer   = out_valid && out_ready;

  assign we    = !rst && ((state == CLEAR) || wr_acc);
  assign waddr = (state == CLEAR) ? clr_cnt : {z_i, z_j};
  assign wdata = (state == CLEAR) ? '0 : z_out;

  assign out_i = rd_cnt[CNT_W-1:m_len];
  assign out_j = rd_cnt[m_len-1:0];

  result_regfile #(.m(m), .m_len(m_len)) u_regfile (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a ({z_i, z_j}),
    .rdata_a (current_element),
    .raddr_b (rd_cnt),
    .rdata_b (out_data)
  );

  always_comb begin
    state_nxt = state;
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && (rd_cnt == LAST_IDX);
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_IDX) state_nxt = ACCEPT;
      ACCEPT:  if (mul_done) state_nxt = DRAIN;
      DRAIN:   if (xfer && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      rd_cnt  <= '0;
      seen    <= 1'b0;
      z_ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      z_ack <= wr_acc;
      if (!z_stb)      seen <= 1'b0;
      else if (wr_acc) seen <= 1'b1;
      // both counters wrap to 0 naturally after the last entry
      if (state == CLEAR) clr_cnt <= clr_cnt + CNT_ONE;
      else                clr_cnt <= '0;
      if (xfer) rd_cnt <= rd_cnt + CNT_ONE;
    end
  end

endmodule
